// File: rtl/nn_xor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_xor_sequencer
// Brief    : On-chip stimulus/check engine for the XOR neural-network core.
// Revision : 1.0  initial release
// ============================================================================
module nn_xor_sequencer #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANT_WIDTH     = 24,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            start,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w11,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w12,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w21,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w22,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] b1,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] b2,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w31,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] w32,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] b3,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] A,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] B,
    output logic [2:0]                      round_mode,
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] nn_result,
    input  logic                            nn_ready,
    output logic                            busy,
    output logic                            done,
    output logic [3:0]                      result_bits,
    output logic [EXP_WIDTH+MANT_WIDTH-1:0] last_result,
    output logic                            pass,
    output logic                            timeout_err
);
    localparam int DW      = EXP_WIDTH + MANT_WIDTH;
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int c_frac  = MANT_WIDTH - 1;

    // Float constants are assembled from the exponent bias so the engine tracks the format.
    localparam logic [EXP_WIDTH-1:0] c_bias = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [DW-1:0] c_pos1 = {1'b0, c_bias, {c_frac{1'b0}}};
    localparam logic [DW-1:0] c_pos4 = {1'b0, c_bias + EXP_WIDTH'(2), {c_frac{1'b0}}};
    localparam logic [DW-1:0] c_neg4 = {1'b1, c_bias + EXP_WIDTH'(2), {c_frac{1'b0}}};
    localparam logic [DW-1:0] c_neg2 = {1'b1, c_bias + EXP_WIDTH'(1), {c_frac{1'b0}}};
    localparam logic [DW-1:0] c_pos6 = {1'b0, c_bias + EXP_WIDTH'(2), 1'b1, {(c_frac-1){1'b0}}};
    localparam logic [DW-1:0] c_neg6 = {1'b1, c_bias + EXP_WIDTH'(2), 1'b1, {(c_frac-1){1'b0}}};
    localparam logic [DW-2:0] c_half = {c_bias - EXP_WIDTH'(1), {c_frac{1'b0}}};

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_apply   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_finish  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_settled;
    logic               w_expired;
    logic               w_begin;
    logic               w_load;
    logic               w_count;
    logic               w_timeout;
    logic               w_capture;
    logic               w_finish;
    logic               w_above_half;

    assign w11        = c_pos4;
    assign w12        = c_pos4;
    assign w21        = c_neg4;
    assign w22        = c_neg4;
    assign b1         = c_neg2;
    assign b2         = c_pos6;
    assign w31        = c_pos4;
    assign w32        = c_pos4;
    assign b3         = c_neg6;
    assign round_mode = 3'b000;

    // Ready is honoured once the edge leaving WAIT brings cnt to SETTLE_CYCLES,
    // so a stale ready left over from the previous vector is never sampled.
    assign w_settled    = (r_cnt >= c_cnt_w'(SETTLE_CYCLES - 1)) && nn_ready;
    assign w_expired    = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
    assign w_above_half = ~nn_result[DW-1] & (nn_result[DW-2:0] > c_half);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= c_st_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (start) w_next_state = c_st_apply;
            c_st_apply:   w_next_state = c_st_wait;
            c_st_wait: begin
                if (w_settled)      w_next_state = c_st_capture;
                else if (w_expired) w_next_state = c_st_finish;
            end
            c_st_capture: w_next_state = (r_idx == 2'd3) ? c_st_finish : c_st_apply;
            c_st_finish:  w_next_state = c_st_idle;
            default:      w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_begin   = (r_state == c_st_idle) && start;
        w_load    = (r_state == c_st_apply);
        w_count   = (r_state == c_st_wait);
        w_timeout = (r_state == c_st_wait) && !w_settled && w_expired;
        w_capture = (r_state == c_st_capture);
        w_finish  = (r_state == c_st_finish);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            A           <= '0;
            B           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_bits <= 4'd0;
            last_result <= '0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= w_finish;
            if (w_begin) begin
                result_bits <= 4'd0;
                pass        <= 1'b0;
                timeout_err <= 1'b0;
                r_idx       <= 2'd0;
                busy        <= 1'b1;
            end
            if (w_load) begin
                A     <= r_idx[1] ? c_pos1 : '0;
                B     <= r_idx[0] ? c_pos1 : '0;
                r_cnt <= '0;
            end
            if (w_count && !(&r_cnt)) r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_timeout) timeout_err <= 1'b1;
            if (w_capture) begin
                last_result        <= nn_result;
                result_bits[r_idx] <= w_above_half;
                if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
            end
            if (w_finish) begin
                pass <= (result_bits == 4'b0110) && !timeout_err;
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_xor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_xor_sequencer
// Brief    : Scoreboard bench for nn_xor_sequencer with a behavioural XOR core.
// Revision : 1.0  initial release
// ============================================================================
module tb_nn_xor_sequencer;
    localparam logic [31:0] c_one = 32'h3F800000;

    typedef struct {
        logic [3:0]  bits;
        logic        pass;
        logic        to;
        logic [31:0] last;
        int          lat;
        int          gap;
    } done_t;

    typedef struct {
        logic [63:0] ab;
        int          at;
    } ab_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start = 1'b0;
    logic [31:0] w11, w12, w21, w22, b1, b2, w31, w32, b3, A, B, nn_result, last_result;
    logic [2:0]  round_mode;
    logic        nn_ready, busy, done, pass, timeout_err;
    logic [3:0]  result_bits;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int last_ab_cyc = 0;
    logic [63:0] last_ab = '0;
    logic [63:0] mon_ab  = '0;
    done_t done_q[$];
    ab_t   ab_q[$];

    // Behavioural core: ready rises a fixed delay after the operands change.
    logic [31:0] resp [4];
    logic [63:0] prev_ab = '0;
    int          dly = 0;
    int          ready_delay = 80;
    bit          stuck1 = 1'b0;
    bit          stall_en = 1'b0;
    logic [1:0]  stall_vec = 2'd2;
    logic [1:0]  vec;

    nn_xor_sequencer dut (
        .clk(clk), .rst_l(rst_l), .start(start),
        .w11(w11), .w12(w12), .w21(w21), .w22(w22), .b1(b1), .b2(b2),
        .w31(w31), .w32(w32), .b3(b3), .A(A), .B(B), .round_mode(round_mode),
        .nn_result(nn_result), .nn_ready(nn_ready), .busy(busy), .done(done),
        .result_bits(result_bits), .last_result(last_result), .pass(pass),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if ({A, B} != prev_ab) begin
            prev_ab <= {A, B};
            dly     <= 0;
        end else if (dly < 100000) begin
            dly <= dly + 1;
        end
    end

    assign vec       = {A == c_one, B == c_one};
    assign nn_result = resp[vec];

    always_comb begin
        nn_ready = (dly >= ready_delay);
        if (stall_en && vec == stall_vec) nn_ready = 1'b0;
        if (stuck1) nn_ready = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: pops expectations whenever the DUT moves the operands or pulses done.
    initial begin
        done_t d;
        ab_t   a;
        forever begin
            @(negedge clk);
            if ({A, B} != mon_ab) begin
                if (busy) begin
                    if (ab_q.size() == 0) chk("ab_unexpected", {A, B}, 64'h0);
                    else begin
                        a = ab_q.pop_front();
                        chk("ab_seq", {A, B}, a.ab);
                        if (a.at >= 0) chk("ab_time", 64'(cyc), 64'(a.at));
                    end
                end
                mon_ab      = {A, B};
                last_ab_cyc = cyc;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'h0);
                else begin
                    d = done_q.pop_front();
                    chk("result_bits", 64'(result_bits), 64'(d.bits));
                    chk("pass", 64'(pass), 64'(d.pass));
                    chk("timeout_err", 64'(timeout_err), 64'(d.to));
                    chk("last_result", 64'(last_result), 64'(d.last));
                    chk("busy_at_done", 64'(busy), 64'h0);
                    if (d.lat > 0) chk("latency", 64'(cyc - t_start), 64'(d.lat));
                    if (d.gap > 0) chk("wait_gap", 64'(cyc - last_ab_cyc), 64'(d.gap));
                end
            end
        end
    end

    task automatic set_resp(input logic [31:0] r0, r1, r2, r3);
        resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
    endtask

    task automatic push_ab(input int n, input bit timed);
        for (int i = 0; i < n; i++) begin
            ab_t         it;
            logic [63:0] v;
            v = {(i >= 2) ? c_one : 32'h0, (i % 2 == 1) ? c_one : 32'h0};
            if (v != last_ab) begin
                it.ab = v;
                it.at = timed ? (t_start + 2 + i * 66) : -1;
                ab_q.push_back(it);
            end
            last_ab = v;
        end
    endtask

    task automatic wait_done(input int nd0, input int budget);
        for (int i = 0; i < budget && n_done == nd0; i++) @(posedge clk);
        chk("done_seen", 64'(n_done != nd0), 64'h1);
    endtask

    task automatic run(input logic [3:0] eb, input logic ep, input logic eto,
                       input logic [31:0] el, input int nvec, input int lat,
                       input int gap, input bit timed);
        done_t d;
        int    nd0;
        @(posedge clk); #1;
        t_start = cyc;
        d.bits = eb; d.pass = ep; d.to = eto; d.last = el; d.lat = lat; d.gap = gap;
        done_q.push_back(d);
        push_ab(nvec, timed);
        nd0   = n_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(nd0, 3000);
        repeat (3) @(posedge clk);
        chk("done_once", 64'(n_done - nd0), 64'h1);
        chk("busy_after", 64'(busy), 64'h0);
    endtask

    initial begin
        int  nd0;
        bit  found;
        rst_l = 1'b0;
        set_resp(32'h3C000000, 32'h3F7F0000, 32'h3F7F0000, 32'h3C000000);
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_bits", 64'(result_bits), 64'h0);
        chk("rst_last", 64'(last_result), 64'h0);
        chk("rst_pass", 64'(pass), 64'h0);
        chk("rst_to", 64'(timeout_err), 64'h0);
        chk("rst_ab", {A, B}, 64'h0);
        chk("w11", 64'(w11), 64'h40800000);
        chk("w12", 64'(w12), 64'h40800000);
        chk("w21", 64'(w21), 64'hC0800000);
        chk("w22", 64'(w22), 64'hC0800000);
        chk("b1", 64'(b1), 64'hC0000000);
        chk("b2", 64'(b2), 64'h40C00000);
        chk("w31", 64'(w31), 64'h40800000);
        chk("w32", 64'(w32), 64'h40800000);
        chk("b3", 64'(b3), 64'hC0C00000);
        chk("round_mode", 64'(round_mode), 64'h0);
        rst_l = 1'b1;

        // Nominal XOR run.
        run(4'b0110, 1'b1, 1'b0, 32'h3C000000, 4, 0, 0, 1'b0);
        // Every vector above threshold.
        set_resp(32'h3F7F0000, 32'h3F7F0000, 32'h3F7F0000, 32'h3F7F0000);
        run(4'b1111, 1'b0, 1'b0, 32'h3F7F0000, 4, 0, 0, 1'b0);
        // Threshold edges: exactly 0.5, negative, just above 0.5, NaN.
        set_resp(32'h3F000000, 32'hBF800000, 32'h3F000001, 32'h7FC00000);
        run(4'b1100, 1'b0, 1'b0, 32'h7FC00000, 4, 0, 0, 1'b0);
        // Core never ready on vector 2: timeout after 1024 WAIT cycles.
        set_resp(32'h3C000000, 32'h3F7F0000, 32'h3F7F0000, 32'h3C000000);
        stall_en = 1'b1;
        run(4'b0010, 1'b0, 1'b1, 32'h3F7F0000, 3, 0, 1025, 1'b0);
        stall_en = 1'b0;
        // Ready stuck high: minimum latency, and a second start mid-run is ignored.
        stuck1 = 1'b1;
        fork
            run(4'b0110, 1'b1, 1'b0, 32'h3C000000, 4, 266, 66, 1'b1);
            begin
                repeat (100) @(posedge clk); #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        stuck1 = 1'b0;

        // Reset during the WAIT of vector 1.
        nd0 = n_done;
        @(posedge clk); #1;
        push_ab(2, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if ({A, B} == {32'h0, c_one}) found = 1'b1;
        end
        chk("reach_vec1", 64'(found), 64'h1);
        repeat (10) @(posedge clk);
        #3 rst_l = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_ab", {A, B}, 64'h0);
        chk("arst_last", 64'(last_result), 64'h0);
        chk("arst_bits", 64'(result_bits), 64'h0);
        last_ab = '0;
        repeat (2) @(posedge clk);
        #3 rst_l = 1'b1;
        repeat (300) @(posedge clk);
        chk("no_done_after_rst", 64'(n_done - nd0), 64'h0);
        run(4'b0110, 1'b1, 1'b0, 32'h3C000000, 4, 0, 0, 1'b0);

        repeat (5) @(posedge clk);
        chk("done_q_empty", 64'(done_q.size()), 64'h0);
        chk("ab_q_empty", 64'(ab_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
